// File: rtl/ri5cy_data_mem_responder.sv
// Memory-side responder for the RI5CY data port: single outstanding
// req/gnt/rvalid transaction, configurable grant stall and response latency,
// word-addressed backing array, and read/write completion counters.
module ri5cy_data_mem_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int GNT_DELAY  = 0,
   parameter int LATENCY    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic [31:0]             read_count_o,
   output logic [31:0]             write_count_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int BE_W  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, STALL, BUSY, RESP} state_t;

   state_t                state;
   logic [31:0]           stall_cnt;
   logic [31:0]           lat_cnt;
   logic                  hold_we;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      idx;
   logic                  accept;

   // Byte address to word index; upper bits beyond the array simply alias.
   assign idx = IDX_W'(data_addr_i >> 2);

   // Grant decode: immediate in IDLE when there is no stall, or once the
   // stall counter has run out while req is still held.
   always_comb begin
      accept = 1'b0;
      if (rst_n && data_req_i) begin
         if (state == IDLE && GNT_DELAY == 0)
            accept = 1'b1;
         else if (state == STALL && stall_cnt == 32'd0)
            accept = 1'b1;
      end
   end

   assign data_gnt_o = accept;

   // Writes land in the array at the accept edge, so a following read sees them.
   always_ff @(posedge clk) begin
      if (accept && data_we_i) begin
         for (int i = 0; i < BE_W; i++)
            if (data_be_i[i])
               mem[idx][i*8 +: 8] <= data_wdata_i[i*8 +: 8];
      end
   end

   // Transaction FSM with registered response outputs and completion counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         stall_cnt     <= '0;
         lat_cnt       <= '0;
         hold_we       <= 1'b0;
         hold          <= '0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         read_count_o  <= '0;
         write_count_o <= '0;
      end else begin
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         if (accept) begin
            hold_we <= data_we_i;
            hold    <= mem[idx];
            if (LATENCY == 1) begin
               // Response goes out in the very next cycle straight from the array.
               state         <= RESP;
               data_rvalid_o <= 1'b1;
               data_rdata_o  <= data_we_i ? '0 : mem[idx];
            end else begin
               state   <= BUSY;
               lat_cnt <= 32'(LATENCY - 2);
            end
         end else begin
            case (state)
               IDLE: begin
                  if (data_req_i && GNT_DELAY > 0) begin
                     state     <= STALL;
                     stall_cnt <= 32'(GNT_DELAY - 1);
                  end
               end
               STALL: begin
                  if (!data_req_i)
                     state <= IDLE;
                  else
                     stall_cnt <= stall_cnt - 32'd1;
               end
               BUSY: begin
                  if (lat_cnt == 32'd0) begin
                     state         <= RESP;
                     data_rvalid_o <= 1'b1;
                     data_rdata_o  <= hold_we ? '0 : hold;
                  end else begin
                     lat_cnt <= lat_cnt - 32'd1;
                  end
               end
               RESP: begin
                  state <= IDLE;
                  if (hold_we)
                     write_count_o <= write_count_o + 32'd1;
                  else
                     read_count_o <= read_count_o + 32'd1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ri5cy_data_mem_responder.sv
// Directed bench for ri5cy_data_mem_responder. Three instances cover the
// (GNT_DELAY, LATENCY) configurations (0,2), (3,1) and (0,4); expected read
// data comes from a bench-side memory model and is queued at issue time.
module tb_ri5cy_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic        req   [3];
   logic [15:0] addr  [3];
   logic        we    [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   logic        gnt   [3];
   logic        rvalid[3];
   logic [31:0] rdata [3];
   logic [31:0] rc    [3];
   logic [31:0] wc    [3];

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [int];
   logic [31:0] exp_rc [3];
   logic [31:0] exp_wc [3];
   logic [31:0] last_rdata;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int GD = (g == 1) ? 3 : 0;
      localparam int LT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      ri5cy_data_mem_responder #(
         .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4096),
         .GNT_DELAY(GD), .LATENCY(LT)
      ) dut (
         .clk(clk), .rst_n(rst_n[g]),
         .data_req_i(req[g]), .data_addr_i(addr[g]), .data_we_i(we[g]),
         .data_be_i(be[g]), .data_wdata_i(wdata[g]),
         .data_gnt_o(gnt[g]), .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]),
         .read_count_o(rc[g]), .write_count_o(wc[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int mkey(input int d, input logic [15:0] a);
      return d * 4096 + int'((a >> 2) & 16'h0FFF);
   endfunction

   function automatic logic [31:0] model_rd(input int d, input logic [15:0] a);
      if (model.exists(mkey(d, a))) return model[mkey(d, a)];
      return 32'h0;
   endfunction

   task automatic model_wr(input int d, input logic [15:0] a, input logic [3:0] b,
                           input logic [31:0] wd);
      logic [31:0] w;
      w = model_rd(d, a);
      for (int i = 0; i < 4; i++)
         if (b[i]) w[i*8 +: 8] = wd[i*8 +: 8];
      model[mkey(d, a)] = w;
   endtask

   // One complete transaction: checks grant wait, response latency, data and counters.
   task automatic do_txn(input int d, input logic w, input logic [15:0] a,
                         input logic [3:0] b, input logic [31:0] wd,
                         input int gwait, input int lat, input string tag);
      int n;
      int m;
      logic [31:0] e;
      @(posedge clk); #1;
      req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
      if (w) begin
         exp_q.push_back(32'h0);
         model_wr(d, a, b, wd);
         exp_wc[d] = exp_wc[d] + 1;
      end else begin
         exp_q.push_back(model_rd(d, a));
         exp_rc[d] = exp_rc[d] + 1;
      end
      n = 0;
      @(negedge clk);
      while (!gnt[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_gnt_wait"}, n, gwait);
      @(posedge clk); #1;
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 16'hFFFF; wdata[d] = 32'hFFFF_FFFF;
      m = 1;
      @(negedge clk);
      while (!rvalid[d] && m < 20) begin
         @(negedge clk);
         m++;
      end
      check({tag, "_latency"}, m, lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      last_rdata = rdata[d];
      check({tag, "_rdata"}, rdata[d], e);
      @(negedge clk);
      check({tag, "_rvalid_pulse"}, rvalid[d], 1'b0);
      check({tag, "_rdata_idle"}, rdata[d], 32'h0);
      check({tag, "_rcount"}, rc[d], exp_rc[d]);
      check({tag, "_wcount"}, wc[d], exp_wc[d]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int k;
      int pulses;
      int overlap;
      int last_g;
      logic g_seen;
      logic [15:0] bb_addr [4];

      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; addr[d] = '0; we[d] = 1'b0;
         be[d] = 4'h0; wdata[d] = '0; exp_rc[d] = '0; exp_wc[d] = '0;
      end
      req[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset state; gnt must stay low with req high while in reset
      for (int d = 0; d < 3; d++) begin
         check("rst_gnt", gnt[d], 1'b0);
         check("rst_rvalid", rvalid[d], 1'b0);
         check("rst_rdata", rdata[d], 32'h0);
         check("rst_rcount", rc[d], 32'h0);
         check("rst_wcount", wc[d], 32'h0);
      end
      @(posedge clk); #1;
      req[0] = 1'b0;
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

      // basic write then read, immediate gnt, latency 2
      do_txn(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 0, 2, "wr10");
      do_txn(0, 1'b0, 16'h0010, 4'h0, 32'h0, 0, 2, "rd10");
      check("rd10_lit", last_rdata, 32'hDEADBEEF);

      // partial write
      do_txn(0, 1'b1, 16'h0020, 4'hF, 32'h11223344, 0, 2, "wr20");
      do_txn(0, 1'b1, 16'h0020, 4'h5, 32'hAABBCCDD, 0, 2, "pw20");
      do_txn(0, 1'b0, 16'h0020, 4'h0, 32'h0, 0, 2, "rd20");
      check("rd20_lit", last_rdata, 32'h11BB33DD);

      // be=0 write is a no-op
      do_txn(0, 1'b1, 16'h0020, 4'h0, 32'h55555555, 0, 2, "nop20");
      do_txn(0, 1'b0, 16'h0020, 4'h0, 32'h0, 0, 2, "rd20b");
      check("rd20b_lit", last_rdata, 32'h11BB33DD);

      // aliasing: 0x4004 maps onto the same word as 0x0004
      do_txn(0, 1'b1, 16'h0004, 4'hF, 32'h00000001, 0, 2, "wr04");
      do_txn(0, 1'b0, 16'h4004, 4'h0, 32'h0, 0, 2, "rd4004");
      check("alias_lit", last_rdata, 32'h00000001);

      // back-to-back reads with req held continuously
      bb_addr[0] = 16'h0010; bb_addr[1] = 16'h0020;
      bb_addr[2] = 16'h0004; bb_addr[3] = 16'h0010;
      for (int i = 0; i < 4; i++) exp_q.push_back(model_rd(0, bb_addr[i]));
      exp_rc[0] = exp_rc[0] + 4;
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = bb_addr[0];
      k = 0; pulses = 0; overlap = 0; last_g = -1;
      for (int c = 0; c < 40 && pulses < 4; c++) begin
         @(negedge clk);
         g_seen = gnt[0];
         if (rvalid[0]) begin
            pulses++;
            check("b2b_rdata", rdata[0], (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
         end
         if (g_seen && rvalid[0]) overlap++;
         if (g_seen) begin
            if (k > 0) check("b2b_gnt_spacing", c - last_g, 3);
            last_g = c;
            k++;
         end
         @(posedge clk); #1;
         if (g_seen) begin
            if (k < 4) addr[0] = bb_addr[k];
            else req[0] = 1'b0;
         end
      end
      check("b2b_grants", k, 4);
      check("b2b_pulses", pulses, 4);
      check("b2b_overlap", overlap, 0);
      @(negedge clk);
      check("b2b_rcount", rc[0], exp_rc[0]);

      // grant stall of 3, latency 1
      do_txn(1, 1'b1, 16'h0010, 4'hF, 32'h0BADCAFE, 3, 1, "st_wr");
      do_txn(1, 1'b0, 16'h0010, 4'h0, 32'h0, 3, 1, "st_rd");
      check("st_rd_lit", last_rdata, 32'h0BADCAFE);

      // dropped request during stall: nothing happens
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0010; be[1] = 4'hF; wdata[1] = 32'h12121212;
      @(negedge clk);
      n = gnt[1];
      @(posedge clk); #1;
      req[1] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n += int'(gnt[1]) + int'(rvalid[1]);
      end
      check("drop_activity", n, 0);
      check("drop_rcount", rc[1], exp_rc[1]);
      check("drop_wcount", wc[1], exp_wc[1]);
      do_txn(1, 1'b0, 16'h0010, 4'h0, 32'h0, 3, 1, "drop_rd");
      check("drop_rd_lit", last_rdata, 32'h0BADCAFE);

      // reset mid-transaction, latency 4
      do_txn(2, 1'b1, 16'h0044, 4'hF, 32'h12345678, 0, 4, "pre_wr");
      @(posedge clk); #1;
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0040; be[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
      @(negedge clk);
      check("rst_mid_gnt", gnt[2], 1'b1);
      model_wr(2, 16'h0040, 4'hF, 32'hCAFEF00D);
      @(posedge clk); #1;
      req[2] = 1'b0;
      @(posedge clk); #1;
      rst_n[2] = 1'b0;
      @(posedge clk); #1;
      rst_n[2] = 1'b1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n += int'(rvalid[2]);
      end
      check("rst_mid_rvalid", n, 0);
      check("rst_mid_rcount", rc[2], 32'h0);
      check("rst_mid_wcount", wc[2], 32'h0);
      exp_rc[2] = '0; exp_wc[2] = '0;
      do_txn(2, 1'b0, 16'h0040, 4'h0, 32'h0, 0, 4, "rst_rd40");
      check("rst_rd40_lit", last_rdata, 32'hCAFEF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
